vending_fsm_param: RTL

Parametrised next-generation vending controller: accumulates validated coin credit, vends any of NPROD products from a parameter price table, and returns change as a handshaked pulse train of 2- and 1-unit coins. Adds cancel/refund, over-credit coin rejection, invalid-selection flagging, and ready/valid handshakes to the dispenser and change hopper. Sits between the coin acceptor and selection keypad on one side and the product dispenser and change hopper on the other.

---
 rtl/vending_fsm_param.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: collects coin credit, vends from a price table,
// and pays change back as a handshaked train of 2- and 1-unit coins.
module vending_fsm_param #(
    parameter int NPROD = 4,
    parameter int SEL_W = 2,
    parameter int CRED_W = 6,
    parameter int COIN_W = 3,
    parameter int MAX_CREDIT = 31,
    parameter logic [NPROD*CRED_W-1:0] PRICES = {6'd12, 6'd9, 6'd7, 6'd4}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_val,
    input  logic              sel_valid,
    input  logic [SEL_W-1:0]  sel_idx,
    input  logic              cancel,
    input  logic              vend_ready,
    input  logic              chg_ready,
    output logic [CRED_W-1:0] credit,
    output logic              coin_reject,
    output logic              sel_err,
    output logic              vend_valid,
    output logic [SEL_W-1:0]  vend_idx,
    output logic              chg_valid,
    output logic [1:0]        chg_val,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t            state_q, state_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]  vend_idx_q, vend_idx_d;
    logic              coin_reject_q, coin_reject_d;
    logic              sel_err_q, sel_err_d;

    logic              sel_known;
    logic [CRED_W-1:0] sel_price;
    logic [CRED_W:0]   coin_sum;
    logic [CRED_W-1:0] chg_amt;

    // Sum is formed one bit wider so an over-limit coin can never wrap back into range.
    function automatic logic coin_fits(input logic [CRED_W:0] sum, input logic [COIN_W-1:0] val);
        return (val != '0) && (sum <= (CRED_W+1)'(MAX_CREDIT));
    endfunction

    always_comb begin
        sel_known = 1'b0;
        sel_price = '0;
        for (int i = 0; i < NPROD; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                sel_known = 1'b1;
                sel_price = PRICES[i*CRED_W +: CRED_W];
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + (CRED_W+1)'(coin_val);
    assign chg_amt  = (credit_q >= CRED_W'(2)) ? CRED_W'(2) : CRED_W'(1);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_idx_d    = vend_idx_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (cancel) begin
                    if (credit_q != '0) state_d = S_CHANGE;
                    coin_reject_d = coin_valid;
                end else if (sel_valid && sel_known && (credit_q >= sel_price)) begin
                    vend_idx_d    = sel_idx;
                    credit_d      = credit_q - sel_price;
                    state_d       = S_VEND;
                    coin_reject_d = coin_valid;
                end else begin
                    // A refused selection still lets a same-cycle coin through.
                    sel_err_d = sel_valid;
                    if (coin_valid) begin
                        if (coin_fits(coin_sum, coin_val)) begin
                            credit_d = coin_sum[CRED_W-1:0];
                            state_d  = S_COLLECT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_ready) state_d = (credit_q == '0) ? S_IDLE : S_CHANGE;
            end
            default: begin
                coin_reject_d = coin_valid;
                if (chg_ready) begin
                    credit_d = credit_q - chg_amt;
                    if (credit_q == chg_amt) state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_idx_q    <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_idx_q    <= vend_idx_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign vend_valid  = (state_q == S_VEND);
    assign vend_idx    = vend_idx_q;
    assign chg_valid   = (state_q == S_CHANGE);
    assign chg_val     = chg_valid ? chg_amt[1:0] : 2'd0;
    assign busy        = vend_valid | chg_valid;

endmodule
